// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and constants for the sequential 8x8 multiplier
package seq_mult_pkg;

  localparam int NIB_W = 4;

  localparam int SH0 = 0;
  localparam int SH1 = NIB_W;
  localparam int SH2 = 2 * NIB_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pass 0 weighs 1, passes 1 and 2 weigh one nibble, pass 3 weighs two nibbles.
  function automatic int shift_of(input logic [1:0] cnt, input int nib_w);
    case (cnt)
      2'd0:    shift_of = 0;
      2'd3:    shift_of = 2 * nib_w;
      default: shift_of = nib_w;
    endcase
  endfunction

endpackage

// File: rtl/pp_shifter.sv
// rtl/pp_shifter.sv - zero-extends and weights the 4x4 partial product for the current pass
module pp_shifter
  import seq_mult_pkg::*;
#(
  parameter int NIB_W = seq_mult_pkg::NIB_W
) (
  input  logic [2*NIB_W-1:0] pp_in,
  input  logic [1:0]         cnt,
  output logic [4*NIB_W-1:0] addend
);

  logic [4*NIB_W-1:0] pp_ext;

  always_comb begin
    pp_ext = {{(2*NIB_W){1'b0}}, pp_in};
    addend = pp_ext << shift_of(cnt, NIB_W);
  end

endmodule

// File: rtl/seq_mult_ctrl_accum.sv
// rtl/seq_mult_ctrl_accum.sv - control FSM, pass counter and accumulator of the sequential multiplier
module seq_mult_ctrl_accum
  import seq_mult_pkg::*;
#(
  parameter int NIB_W = seq_mult_pkg::NIB_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2*NIB_W-1:0] pp_in,
  output logic               sel_a,
  output logic               sel_b,
  output logic [4*NIB_W-1:0] result,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [4*NIB_W-1:0] acc_q, acc_d;
  logic               sel_a_q, sel_a_d;
  logic               sel_b_q, sel_b_d;
  logic [4*NIB_W-1:0] addend;

  pp_shifter #(.NIB_W(NIB_W)) u_pp_shifter (
    .pp_in  (pp_in),
    .cnt    (cnt_q),
    .addend (addend)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = 2'd0;
          acc_d   = '0;
        end
      end
      CALC: begin
        acc_d = acc_q + addend;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
    // Selects are registered from the next pass so pp_in is settled for the whole CALC cycle.
    sel_a_d = (state_d == CALC) && cnt_d[0];
    sel_b_d = (state_d == CALC) && cnt_d[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      acc_q   <= '0;
      sel_a_q <= 1'b0;
      sel_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign sel_a  = sel_a_q;
  assign sel_b  = sel_b_q;
  assign result = acc_q;
  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_seq_mult_ctrl_accum.sv
// tb/tb_seq_mult_ctrl_accum.sv - self-checking bench for seq_mult_ctrl_accum
module tb_seq_mult_ctrl_accum;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  pp_in;
  logic        sel_a;
  logic        sel_b;
  logic [15:0] result;
  logic        busy;
  logic        done;

  logic [7:0]  a_op;
  logic [7:0]  b_op;
  logic [3:0]  na;
  logic [3:0]  nb;

  int tests_run;
  int failures;

  seq_mult_ctrl_accum dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .pp_in   (pp_in),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream nibble muxes and 4x4 multiplier.
  always_comb begin
    na    = sel_a ? a_op[7:4] : a_op[3:0];
    nb    = sel_b ? b_op[7:4] : b_op[3:0];
    pp_in = {4'b0, na} * {4'b0, nb};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [15:0] exp_result);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || sel_a !== 1'b0 || sel_b !== 1'b0 || result !== exp_result) begin
      failures++;
      $display("FAIL %s: busy=%b done=%b sel_a=%b sel_b=%b result=%h, required 0 0 0 0 %h",
               tag, busy, done, sel_a, sel_b, result, exp_result);
    end
  endtask

  // Starts one multiply (start sampled at the next edge) and checks every cycle up to done.
  // pulse_at >= 0 re-asserts start for one cycle while the run is still in CALC.
  task automatic run_mult(input string tag, input logic [7:0] a, input logic [7:0] b, input int pulse_at);
    logic [15:0] exp_acc;
    logic [15:0] exp_prod;
    logic [3:0]  ma;
    logic [3:0]  mb;
    a_op     = a;
    b_op     = b;
    exp_prod = 16'(a) * 16'(b);
    exp_acc  = '0;
    start    = 1'b1;
    step();
    start    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (busy !== 1'b1 || done !== 1'b0 || sel_a !== i[0] || sel_b !== i[1] || result !== exp_acc) begin
        failures++;
        $display("FAIL %s pass%0d: busy=%b done=%b sel_a=%b sel_b=%b result=%h, required 1 0 %b %b %h",
                 tag, i, busy, done, sel_a, sel_b, result, i[0], i[1], exp_acc);
      end
      ma      = i[0] ? a[7:4] : a[3:0];
      mb      = i[1] ? b[7:4] : b[3:0];
      exp_acc = exp_acc + ((16'(ma) * 16'(mb)) << (4 * (int'(i[0]) + int'(i[1]))));
      start   = (i == pulse_at);
      step();
    end
    start = 1'b0;
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || sel_a !== 1'b0 || sel_b !== 1'b0 || result !== exp_prod) begin
      failures++;
      $display("FAIL %s done: done=%b busy=%b sel_a=%b sel_b=%b result=%h, required 1 0 0 0 %h",
               tag, done, busy, sel_a, sel_b, result, exp_prod);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    a_op    = 8'h00;
    b_op    = 8'h00;
    step();
    step();
    check_idle_outputs("reset", 16'h0000);
    reset_n = 1'b1;
    step();
    check_idle_outputs("idle_after_reset", 16'h0000);
  endtask

  task automatic test_basic();
    run_mult("mul_12x34", 8'h12, 8'h34, -1);
    step();
    step();
    tests_run++;
    if (done !== 1'b1 || result !== 16'h03A8) begin
      failures++;
      $display("FAIL hold_done: done=%b result=%h, required 1 03a8", done, result);
    end
  endtask

  task automatic test_max();
    run_mult("mul_ffxff", 8'hFF, 8'hFF, -1);
  endtask

  task automatic test_back_to_back();
    run_mult("mul_00xa7", 8'h00, 8'hA7, -1);
    step();
    run_mult("mul_01x01_from_done", 8'h01, 8'h01, -1);
  endtask

  task automatic test_start_while_busy();
    run_mult("mul_12x34_pulse", 8'h12, 8'h34, 1);
    step();
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignored_start_after: done=%b busy=%b, required 1 0", done, busy);
    end
  endtask

  task automatic test_reset_mid_calc();
    a_op  = 8'h12;
    b_op  = 8'h34;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check_idle_outputs("async_reset_mid_calc", 16'h0000);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check_idle_outputs("post_reset_idle", 16'h0000);
    end
  endtask

  task automatic test_start_held();
    a_op  = 8'h0F;
    b_op  = 8'hF0;
    start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      tests_run++;
      if ((c == 4 || c == 9) ? (done !== 1'b1 || busy !== 1'b0 || result !== 16'h0E10)
                             : (done !== 1'b0 || busy !== 1'b1)) begin
        failures++;
        $display("FAIL held_start c%0d: done=%b busy=%b result=%h, required done=%0d result 0e10 at done",
                 c, done, busy, result, (c == 4 || c == 9));
      end
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    tests_run++;
    if (done !== 1'b1 || result !== 16'h0E10) begin
      failures++;
      $display("FAIL held_start_tail: done=%b result=%h, required 1 0e10", done, result);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra;
    logic [7:0] rb;
    int         pa;
    for (int n = 0; n < 10; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      pa = int'($urandom_range(0, 4)) - 1;
      run_mult("random", ra, rb, pa);
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  initial begin
    tests_run = 0;
    failures  = 0;
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_calc();
    test_start_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
